// File: rtl/npu_pkg.sv
// Shared definitions for the NPU result reader: FSM encoding, default sizing
// and score width.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned N_CLASS_DEF = 10;
  localparam int unsigned TIMEOUT_DEF = 1000;
  localparam int unsigned SCORE_W     = 8;
  localparam int unsigned IDX_W       = 4;

  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/npu_argmax_acc.sv
// Running signed maximum of the frame scores and the index where it occurred.
module npu_argmax_acc
  import npu_pkg::*;
(
  input  logic                      CLKEXT,
  input  logic                      RST_GLO_N,
  input  logic                      init,
  input  logic                      load_first,
  input  logic                      update,
  input  logic signed [SCORE_W-1:0] score,
  input  logic        [IDX_W-1:0]   idx,
  output logic signed [SCORE_W-1:0] max_score,
  output logic        [IDX_W-1:0]   max_idx
);

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      max_score <= '0;
      max_idx   <= '0;
    end else if (init) begin
      max_score <= SCORE_MIN;
      max_idx   <= '0;
    end else if (load_first) begin
      max_score <= score;
      max_idx   <= idx;
    end else if (update && (score > max_score)) begin
      max_score <= score;
      max_idx   <= idx;
    end
  end

endmodule

// File: rtl/npu_result_reader.sv
// Pops N_CLASS signed scores from the NPU output FIFO and reports the argmax
// class, with a per-byte timeout on a stalled FIFO.
module npu_result_reader
  import npu_pkg::*;
#(
  parameter int unsigned N_CLASS = N_CLASS_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLKEXT,
  input  logic               RST_GLO_N,
  input  logic               START,
  input  logic               CLR,
  input  logic               EMPTY,
  input  logic [SCORE_W-1:0] D_OUT,
  output logic               RD_EN,
  output logic [IDX_W-1:0]   CLASS_IDX,
  output logic [SCORE_W-1:0] CLASS_SCORE,
  output logic               VALID,
  input  logic               ACK,
  output logic               BUSY,
  output logic               ERR
);

  localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   byte_cnt_q;
  logic [TW-1:0]      tmo_cnt_q;
  logic               err_q;
  logic               start_frame;
  logic               capt;
  logic               tmo_hit;
  logic [SCORE_W-1:0] max_score;
  logic [IDX_W-1:0]   max_idx;

  always_comb begin
    state_d     = state_q;
    RD_EN       = 1'b0;
    start_frame = 1'b0;
    capt        = 1'b0;
    tmo_hit     = 1'b0;
    if (CLR) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            start_frame = 1'b1;
            state_d     = ST_POP;
          end
        end
        ST_POP: begin
          if (!EMPTY) begin
            RD_EN   = 1'b1;
            state_d = ST_CAPT;
          end else if (tmo_cnt_q >= TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_CAPT: begin
          capt    = 1'b1;
          state_d = (byte_cnt_q < LAST_IDX) ? ST_POP : ST_DONE;
        end
        ST_DONE: begin
          if (ACK) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // tmo_cnt_q holds the number of cycles since the last pop (or START), the
  // pop cycle counting as one; the increment that would reach TIMEOUT ends
  // the frame, so DONE lands exactly TIMEOUT cycles after the last pop.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else if (CLR) begin
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start_frame)  byte_cnt_q <= '0;
      else if (capt)    byte_cnt_q <= byte_cnt_q + IDX_W'(1);

      if (start_frame || RD_EN)              tmo_cnt_q <= TW'(1);
      else if ((state_q == ST_POP) || capt)  tmo_cnt_q <= tmo_cnt_q + TW'(1);

      if (start_frame)                         err_q <= 1'b0;
      else if (tmo_hit)                        err_q <= 1'b1;
      else if ((state_q == ST_DONE) && ACK)    err_q <= 1'b0;
    end
  end

  npu_argmax_acc u_acc (
    .CLKEXT     (CLKEXT),
    .RST_GLO_N  (RST_GLO_N),
    .init       (start_frame),
    .load_first (capt && (byte_cnt_q == '0)),
    .update     (capt && (byte_cnt_q != '0)),
    .score      (D_OUT),
    .idx        (byte_cnt_q),
    .max_score  (max_score),
    .max_idx    (max_idx)
  );

  // Results are only driven while VALID so CLR/ACK return every output to 0.
  always_comb begin
    VALID       = (state_q == ST_DONE);
    BUSY        = (state_q != ST_IDLE);
    ERR         = VALID && err_q;
    CLASS_IDX   = VALID ? max_idx   : '0;
    CLASS_SCORE = VALID ? max_score : '0;
  end

endmodule

// File: tb/tb_npu_result_reader.sv
// Directed bench for npu_result_reader with a behavioural 1-cycle-latency FIFO.
module tb_npu_result_reader;

  logic       CLKEXT = 1'b0;
  logic       RST_GLO_N = 1'b0;
  logic       START = 1'b0;
  logic       CLR = 1'b0;
  logic       ACK = 1'b0;
  logic       EMPTY;
  logic [7:0] D_OUT = '0;
  logic       RD_EN, VALID, BUSY, ERR;
  logic [3:0] CLASS_IDX;
  logic [7:0] CLASS_SCORE;

  logic [7:0] mem [0:255];
  int         wr_n = 0;
  int         rd_n = 0;
  logic       hold_empty = 1'b0;
  logic       flush = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         last_pop = 0;

  localparam logic [79:0] F_MAIN = {8'h04, 8'h80, 8'h00, 8'h01, 8'h7F,
                                    8'h02, 8'h7F, 8'h09, 8'hFD, 8'h05};
  localparam logic [79:0] F_MIN  = {10{8'h80}};
  localparam logic [79:0] F_RISE = {8'h64, 8'h5A, 8'h50, 8'h46, 8'h3C,
                                    8'h32, 8'h28, 8'h1E, 8'h14, 8'h0A};
  localparam logic [79:0] F_NEG  = {8'hFE, 8'hF4, 8'hF5, 8'hF6, 8'hF7,
                                    8'hF8, 8'hFF, 8'hF9, 8'hFA, 8'hFB};
  localparam logic [79:0] F_LAST = {8'h01, {9{8'h00}}};

  always #5 CLKEXT = ~CLKEXT;

  always_comb EMPTY = hold_empty || (rd_n >= wr_n);

  always @(posedge CLKEXT) begin
    if (flush) rd_n <= wr_n;
    else if (RD_EN) begin
      D_OUT <= mem[rd_n];
      rd_n  <= rd_n + 1;
    end
  end

  npu_result_reader #(.N_CLASS(10), .TIMEOUT(16)) dut (
    .CLKEXT      (CLKEXT),
    .RST_GLO_N   (RST_GLO_N),
    .START       (START),
    .CLR         (CLR),
    .EMPTY       (EMPTY),
    .D_OUT       (D_OUT),
    .RD_EN       (RD_EN),
    .CLASS_IDX   (CLASS_IDX),
    .CLASS_SCORE (CLASS_SCORE),
    .VALID       (VALID),
    .ACK         (ACK),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  task automatic push(input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_n] = v[8*i +: 8];
      wr_n++;
    end
  endtask

  // Pulses START, waits for VALID; optionally stalls the FIFO for 5 cycles
  // once gap_at bytes of this frame have been popped.
  task automatic start_wait(input int gap_at, output int cyc);
    int  base;
    int  gap_cnt;
    bit  gap_on;
    base = rd_n; gap_cnt = 0; gap_on = 0;
    START = 1'b1;
    @(negedge CLKEXT);
    START = 1'b0;
    cyc = 0;
    last_pop = -1;
    while (!VALID && cyc < 200) begin
      if (RD_EN) last_pop = cyc;
      @(negedge CLKEXT);
      cyc++;
      if (gap_at > 0 && !gap_on && rd_n == base + gap_at) begin
        hold_empty = 1'b1;
        gap_on = 1;
      end else if (gap_on && hold_empty) begin
        gap_cnt++;
        checks++;
        if (RD_EN !== 1'b0) begin
          errors++;
          $display("FAIL gap_rd_en: got %b expected 0 (gap cycle %0d)", RD_EN, gap_cnt);
        end
        if (gap_cnt == 6) begin
          hold_empty = 1'b0;
          #1;
        end
      end
    end
    checks++;
    if (!VALID) begin
      errors++;
      $display("FAIL valid_wait: VALID not seen within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    RST_GLO_N = 1'b0;
    #2;
    checks++;
    if ({RD_EN, VALID, BUSY, ERR, CLASS_IDX, CLASS_SCORE} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {RD_EN, VALID, BUSY, ERR, CLASS_IDX, CLASS_SCORE});
    end
    @(negedge CLKEXT);
    RST_GLO_N = 1'b1;
    @(negedge CLKEXT);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: BUSY got %b expected 0", BUSY);
    end
  endtask

  task automatic test_basic;
    int cyc;
    push(F_MAIN, 10);
    start_wait(0, cyc);
    checks++;
    if (cyc != 20) begin errors++; $display("FAIL basic_latency: got %0d expected 20", cyc); end
    checks++;
    if (CLASS_IDX !== 4'd3) begin errors++; $display("FAIL basic_idx: got %0d expected 3", CLASS_IDX); end
    checks++;
    if (CLASS_SCORE !== 8'h7F) begin errors++; $display("FAIL basic_score: got %h expected 7f", CLASS_SCORE); end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", ERR); end
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
    checks++;
    if ({VALID, BUSY} !== 2'b00) begin errors++; $display("FAIL basic_ack: VALID,BUSY got %b expected 00", {VALID, BUSY}); end
  endtask

  task automatic test_all_min;
    int cyc;
    push(F_MIN, 10);
    start_wait(0, cyc);
    checks++;
    if (CLASS_IDX !== 4'd0) begin errors++; $display("FAIL min_idx: got %0d expected 0", CLASS_IDX); end
    checks++;
    if (CLASS_SCORE !== 8'h80) begin errors++; $display("FAIL min_score: got %h expected 80", CLASS_SCORE); end
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
  endtask

  task automatic test_gap;
    int cyc;
    push(F_MAIN, 10);
    start_wait(4, cyc);
    checks++;
    if (cyc != 25) begin errors++; $display("FAIL gap_latency: got %0d expected 25", cyc); end
    checks++;
    if ({CLASS_IDX, CLASS_SCORE} !== {4'd3, 8'h7F}) begin
      errors++;
      $display("FAIL gap_result: got %0d/%h expected 3/7f", CLASS_IDX, CLASS_SCORE);
    end
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc;
    int base;
    base = rd_n;
    push(F_MAIN, 3);
    start_wait(0, cyc);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", ERR); end
    checks++;
    if (cyc - last_pop != 16) begin errors++; $display("FAIL tmo_delay: got %0d expected 16", cyc - last_pop); end
    checks++;
    if ({CLASS_IDX, CLASS_SCORE} !== {4'd2, 8'h09}) begin
      errors++;
      $display("FAIL tmo_result: got %0d/%h expected 2/09", CLASS_IDX, CLASS_SCORE);
    end
    checks++;
    if (rd_n - base != 3) begin errors++; $display("FAIL tmo_pops: got %0d expected 3", rd_n - base); end
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
    checks++;
    if ({VALID, ERR} !== 2'b00) begin errors++; $display("FAIL tmo_ack: VALID,ERR got %b expected 00", {VALID, ERR}); end
  endtask

  task automatic test_ack_hold;
    int cyc;
    push(F_RISE, 10);
    start_wait(0, cyc);
    for (int i = 0; i < 7; i++) begin
      START = (i == 3);
      @(negedge CLKEXT);
      checks++;
      if ({VALID, CLASS_IDX, CLASS_SCORE} !== {1'b1, 4'd9, 8'h64}) begin
        errors++;
        $display("FAIL hold_stable: got %b/%0d/%h expected 1/9/64 (cycle %0d)",
                 VALID, CLASS_IDX, CLASS_SCORE, i);
      end
    end
    START = 1'b0;
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
    checks++;
    if ({VALID, BUSY} !== 2'b00) begin errors++; $display("FAIL hold_ack: VALID,BUSY got %b expected 00", {VALID, BUSY}); end
    @(negedge CLKEXT);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: BUSY got %b expected 0", BUSY); end
  endtask

  // use_rst selects the async reset instead of CLR as the abort.
  task automatic test_abort(input bit use_rst, input logic [79:0] fresh,
                            input logic [3:0] exp_idx, input logic [7:0] exp_score);
    int base;
    int n;
    int cyc;
    base = rd_n;
    push(F_MAIN, 10);
    START = 1'b1;
    @(negedge CLKEXT);
    START = 1'b0;
    n = 0;
    while (!(RD_EN && rd_n == base + 6) && n < 40) begin
      @(negedge CLKEXT);
      n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL abort_reach: byte 6 not reached in %0d cycles", n); end
    if (use_rst) RST_GLO_N = 1'b0;
    else         CLR = 1'b1;
    #1;
    checks++;
    if (RD_EN !== 1'b0) begin errors++; $display("FAIL abort_rd_en: got %b expected 0 (rst=%0d)", RD_EN, use_rst); end
    @(negedge CLKEXT);
    CLR = 1'b0;
    RST_GLO_N = 1'b1;
    checks++;
    if ({VALID, BUSY, ERR, CLASS_IDX, CLASS_SCORE} !== 15'h0000) begin
      errors++;
      $display("FAIL abort_outputs: got %h expected 0000 (rst=%0d)",
               {VALID, BUSY, ERR, CLASS_IDX, CLASS_SCORE}, use_rst);
    end
    checks++;
    if (rd_n - base != 6) begin errors++; $display("FAIL abort_pops: got %0d expected 6 (rst=%0d)", rd_n - base, use_rst); end
    flush = 1'b1;
    @(negedge CLKEXT);
    flush = 1'b0;
    base = wr_n;
    push(fresh, 10);
    start_wait(0, cyc);
    checks++;
    if (cyc != 20) begin errors++; $display("FAIL abort_fresh_latency: got %0d expected 20 (rst=%0d)", cyc, use_rst); end
    checks++;
    if ({CLASS_IDX, CLASS_SCORE} !== {exp_idx, exp_score}) begin
      errors++;
      $display("FAIL abort_fresh_result: got %0d/%h expected %0d/%h (rst=%0d)",
               CLASS_IDX, CLASS_SCORE, exp_idx, exp_score, use_rst);
    end
    checks++;
    if (rd_n - base != 10) begin errors++; $display("FAIL abort_fresh_pops: got %0d expected 10 (rst=%0d)", rd_n - base, use_rst); end
    ACK = 1'b1;
    @(negedge CLKEXT);
    ACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_min();
    test_gap();
    test_timeout();
    test_ack_hold();
    test_abort(1'b0, F_NEG, 4'd3, 8'hFF);
    test_abort(1'b1, F_LAST, 4'd9, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
